// File: rtl/mem_ctrl.sv
// Memory access controller: turns single-word read/write strobes from control
// into a bounded-wait req/ack transaction on the external memory bus.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  busy,
  output logic                  fault,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic [31:0]           ext_wdata,
  input  logic                  ext_ack,
  input  logic [31:0]           ext_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  out_of_range;

  // Shifting by the full width yields zero, so ADDR_WIDTH = 32 is legal too.
  assign out_of_range = (addr >> ADDR_WIDTH) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_rd && mem_wr) begin
          state_d = FAULT;
        end else if (mem_rd || mem_wr) begin
          if (out_of_range) begin
            state_d = FAULT;
          end else begin
            addr_d  = addr[ADDR_WIDTH-1:0];
            wdata_d = wdata;
            we_d    = mem_wr;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack on the final wait cycle takes priority over the timeout.
        if (ext_ack) begin
          if (!we_q) rdata_d = ext_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ext_req     = (state_q == REQ);
  assign busy        = (state_q == REQ);
  assign fault       = (state_q == FAULT);
  assign rdata_valid = (state_q == DONE) && !we_q;
  assign ext_we      = we_q;
  assign ext_addr    = addr_q;
  assign ext_wdata   = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (ADDR_WIDTH=16, TIMEOUT=4): vector table of
// single transactions plus hand-written reset sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid, busy, fault, ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_rdata = '0;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .fault(fault), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .ext_rdata(ext_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // REQ cycle index that sees ext_ack; 255 = never
    logic [31:0] ext_rd;
    int          exp_req;    // cycles with ext_req high
    int          exp_fault_at;
    int          exp_valid_at;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int req_n = 0, fault_n = 0, valid_n = 0;
    int fault_at = -1, valid_at = -1, bad_busy = 0, bad_attr = 0;
    mem_rd = v.rd; mem_wr = v.wr; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
    for (int c = 0; c < 10; c++) begin
      if (busy !== ext_req) bad_busy++;
      if (fault === 1'b1) begin fault_n++; if (fault_at < 0) fault_at = c; end
      if (rdata_valid === 1'b1) begin valid_n++; if (valid_at < 0) valid_at = c; end
      if (ext_req === 1'b1) begin
        if (ext_addr !== v.addr[15:0] || ext_we !== v.wr || (v.wr && ext_wdata !== v.wdata))
          bad_attr++;
        ext_ack   = (req_n == v.ack_at);
        ext_rdata = ext_ack ? v.ext_rd : $urandom;
        req_n++;
      end else begin
        ext_ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    ext_ack = 1'b0;
    chk($sformatf("v%0d req_cycles", idx), req_n, v.exp_req);
    chk($sformatf("v%0d fault_count", idx), fault_n, (v.exp_fault_at >= 0) ? 1 : 0);
    chk($sformatf("v%0d fault_at", idx), fault_at, v.exp_fault_at);
    chk($sformatf("v%0d valid_count", idx), valid_n, (v.exp_valid_at >= 0) ? 1 : 0);
    chk($sformatf("v%0d valid_at", idx), valid_at, v.exp_valid_at);
    chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    chk($sformatf("v%0d busy_eq_req", idx), bad_busy, 0);
    chk($sformatf("v%0d bus_attrs", idx), bad_attr, 0);
  endtask

  initial begin
    int req_n, valid_n, fault_n;
    vec_t rec;
    //          rd    wr    addr          wdata         ack  ext_rd        req fault valid rdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        0,  32'hDEADBEEF, 1, -1,  1,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_00FF, 32'h12345678, 3,  32'h55555555, 4, -1, -1,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0,        0,  32'h0,        0,  0, -1,  32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,        0,  32'h0,        0,  0, -1,  32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,        255, 32'h0,       4,  4, -1,  32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        0,  32'hA5A50001, 1, -1,  1,  32'hA5A50001};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,        3,  32'hCAFEF00D, 4, -1,  4,  32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'h8000_0000, 32'h9,        0,  32'h0,        0,  0, -1,  32'hCAFEF00D};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,        2,  32'h0BADF00D, 3, -1,  3,  32'h0BADF00D};

    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset outs", {28'h0, rdata_valid, busy, fault, ext_req}, 32'h0);
    chk("reset ext_we", {31'h0, ext_we}, 32'h0);
    chk("reset ext_addr", {16'h0, ext_addr}, 32'h0);
    chk("reset ext_wdata", ext_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset asserted two cycles into a read, then a stray ack while idle.
    mem_rd = 1'b1; addr = 32'h0000_0050;
    @(posedge clk); #1;
    mem_rd = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset ext_req", {31'h0, ext_req}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("async ext_req", {31'h0, ext_req}, 32'h0);
    chk("async busy", {31'h0, busy}, 32'h0);
    chk("async rdata", rdata, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    req_n = 0; valid_n = 0; fault_n = 0;
    ext_ack = 1'b1; ext_rdata = 32'h77777777;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_n += int'(ext_req); valid_n += int'(rdata_valid); fault_n += int'(fault);
    end
    ext_ack = 1'b0;
    chk("post-reset req", req_n, 0);
    chk("post-reset valid", valid_n, 0);
    chk("post-reset fault", fault_n, 0);
    chk("post-reset rdata", rdata, 32'h0);

    rec = '{1'b1, 1'b0, 32'h0000_0060, 32'h0, 0, 32'h11112222, 1, -1, 1, 32'h11112222};
    run_vec(9, rec);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the CPU control unit and the external memory bus. It accepts single-word read or write strobes from control, runs a request/acknowledge transaction on the external bus with a bounded wait, and returns read data with a one-cycle valid pulse for loading into `ir` or `mdr`. It drives `busy` so control can stall its state machine, and `fault` for illegal or failed accesses.

## Interface
- `ADDR_WIDTH`, default 16: implemented address bits. Any address with bits [31:ADDR_WIDTH] nonzero is out of range.
- `TIMEOUT`, default 255: maximum cycles to wait for `ext_ack`. Valid range is 1..255.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_rd` in 1: read strobe from control; sampled only in IDLE.
- `mem_wr` in 1: write strobe from control; sampled only in IDLE.
- `addr` in 32: word address, sampled with the strobe.
- `wdata` in 32: write data, sampled with the strobe.
- `rdata` out 32: registered read data; held until the next successful read.
- `rdata_valid` out 1: one-cycle pulse when `rdata` is updated.
- `busy` out 1: transaction in progress; control must not issue strobes while high.
- `fault` out 1: one-cycle pulse on an illegal, out-of-range or timed-out access.
- `ext_req` out 1: external request; held until ack or timeout.
- `ext_we` out 1: external write enable; valid while `ext_req` is high.
- `ext_addr` out ADDR_WIDTH: latched address.
- `ext_wdata` out 32: latched write data.
- `ext_ack` in 1: external acknowledge; ignored while `ext_req` is low.
- `ext_rdata` in 32: external read data; valid in the `ext_ack` cycle.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- Reset (asynchronous, while `rst_n` is low):
  - State goes to IDLE.
  - All outputs are 0, including `rdata`, `ext_addr` and `ext_wdata`.
  - Timeout counter is 0.
  - `ext_req` drops immediately, even mid-transaction. An aborted transaction produces no `rdata_valid` and no `fault`.
- IDLE:
  - `mem_rd` XOR `mem_wr` with `addr` in range: latch `addr[ADDR_WIDTH-1:0]`, `wdata`, and `ext_we`=`mem_wr`; clear the counter; go to REQ.
  - `mem_rd` AND `mem_wr`: go to FAULT; no external access.
  - Out-of-range `addr`: go to FAULT; no external access.
  - No strobe: stay in IDLE.
- REQ:
  - `ext_req`=1 and `busy`=1.
  - On `ext_ack`: if read, load `rdata` from `ext_rdata`. Go to DONE.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 with no ack, go to FAULT.
  - An ack in the same cycle the timeout is reached wins: go to DONE.
  - Strobes from control are ignored.
- DONE:
  - `ext_req`=0 and `busy`=0.
  - `rdata_valid`=1 for reads only; writes produce no pulse.
  - Next state is IDLE unconditionally; strobes in DONE are ignored.
- FAULT:
  - `fault`=1 for one cycle, `busy`=0, `ext_req`=0.
  - `rdata` is unchanged.
  - Next state is IDLE.
- Outputs decode from registered state and registers; there is no combinational path from any input to any output.

## Timing
- Strobe sampled at edge E0. `ext_req` and `busy` rise after E0.
- `ext_ack` sampled at edge E1, the earliest possible ack. `rdata_valid` and `rdata` are valid in the cycle after E1, so read latency is at least 2 cycles from the strobe cycle.
- An ack arriving N cycles into REQ gives latency N+2.
- Timeout: `ext_req` stays high for exactly TIMEOUT cycles. FAULT occupies the following cycle.
- Illegal or out-of-range access: `fault` is high in the cycle after the strobe cycle, with `ext_req` never asserted.
- Back-to-back issue: a new strobe is accepted at the earliest in the cycle after DONE or FAULT, i.e. at the IDLE-state edge.

## Test plan
- Read `addr`=0x0010 with `ext_ack` returned 1 cycle into REQ and `ext_rdata`=0xDEADBEEF → `ext_addr`=0x0010 and `ext_we`=0; `rdata`=0xDEADBEEF with `rdata_valid` for exactly 1 cycle; `busy` high for 1 cycle.
- Write `addr`=0x00FF, `wdata`=0x12345678, with ack after 3 wait cycles → `ext_we`=1 and `ext_wdata`=0x12345678 held for 4 cycles; no `rdata_valid`; `rdata` unchanged.
- `mem_rd`=`mem_wr`=1, then separately `addr`=0x00010000 with `ADDR_WIDTH`=16 → each gives a 1-cycle `fault` with `ext_req` never high.
- No ack with `TIMEOUT`=4 → `ext_req` high 4 cycles, then `fault` pulse and return to IDLE; a following read with an immediate ack succeeds.
- Ack exactly on the timeout cycle → DONE with `rdata_valid`; no `fault`.
- Assert `rst_n` low 2 cycles into a read → `ext_req`, `busy` and `rdata` go to 0 asynchronously; no `rdata_valid` or `fault` after release; a late `ext_ack` while idle is ignored.
